// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Brief    : Shared state encoding and sizing helpers for serial_subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int C_DEFAULT_WIDTH = 4;

   // Bit counter needs to reach WIDTH-1; keep at least one bit for WIDTH=2.
   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_fs.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Brief    : Combinational 1-bit full-subtractor cell (d = a - b - bin).
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor (
   input  logic a_i,
   input  logic b_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   assign d_o    = a_i ^ b_i ^ bin_i;
   assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial WIDTH-bit subtractor, LSB first, start/busy/done.
//            Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = C_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            CW     = cnt_width(WIDTH);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, diff_q;
   logic [WIDTH-2:0] sr_q;
   logic [CW-1:0]    cnt_q;
   logic             borrow_q, bout_q, busy_q;
   logic             fs_d, fs_bout;
   logic             accept, last;
   logic [WIDTH-1:0] shift_in;

   full_subtractor u_fs (
      .a_i    (a_q[0]),
      .b_i    (b_q[0]),
      .bin_i  (borrow_q),
      .d_o    (fs_d),
      .bout_o (fs_bout)
   );

   assign accept   = start && (state_q == IDLE || state_q == DONE);
   assign last     = (state_q == RUN) && (cnt_q == C_LAST);
   assign shift_in = {fs_d, sr_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_q == C_LAST) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Diff/Bout only change on the final RUN edge so they hold across a new accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         sr_q     <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         busy_q <= (state_q == RUN) && (cnt_q != C_LAST);
         if (accept) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
         end else if (state_q == RUN) begin
            a_q      <= a_q >> 1;
            b_q      <= b_q >> 1;
            borrow_q <= fs_bout;
            cnt_q    <= cnt_q + CW'(1);
            sr_q     <= shift_in[WIDTH-1:1];
            if (last) begin
               diff_q <= shift_in;
               bout_q <= fs_bout;
            end
         end
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic amsb_q, bmsb_q, ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         amsb_q <= 1'b0;
         bmsb_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         amsb_q <= A[WIDTH-1];
         bmsb_q <= B[WIDTH-1];
      end else if (last) begin
         ovf_q <= (amsb_q ^ bmsb_q) & (fs_d ^ amsb_q);
      end
   end

   assign ovf = ovf_q;
`endif

   assign busy = busy_q;
   assign done = (state_q == DONE);
   assign Diff = diff_q;
   assign Bout = bout_q;

endmodule
`default_nettype wire
